// File: rtl/pulse_gen_monitor_if.sv
// Bundles the pulse monitor's control inputs and measurement outputs.
// master: the side that drives the pulse and controls; slave: the monitor.
interface pulse_gen_monitor_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             pulse_in;
  logic             clear_errs;
  logic [CNT_W-1:0] high_cycles;
  logic [CNT_W-1:0] low_cycles;
  logic             period_valid;
  logic [CNT_W-1:0] pulse_count;
  logic             high_err;
  logic             low_err;
  logic             timeout;

  modport master (
    output enable, pulse_in, clear_errs,
    input  high_cycles, low_cycles, period_valid, pulse_count,
    input  high_err, low_err, timeout
  );

  modport slave (
    input  enable, pulse_in, clear_errs,
    output high_cycles, low_cycles, period_valid, pulse_count,
    output high_err, low_err, timeout
  );
endinterface

// File: rtl/pulse_gen_monitor.sv
// Measures high/low durations of an asynchronous pulse, counts periods and
// flags out-of-tolerance durations or a stalled pulse with sticky errors.
module pulse_gen_monitor #(
  parameter int CNT_W       = 16,
  parameter int EXP_HIGH    = 10,
  parameter int EXP_LOW     = 10,
  parameter int TOL         = 1,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  pulse_gen_monitor_if.slave   mon,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // Tolerance window in CNT_W+1 bits; lower bound clamped at zero.
  localparam logic [CNT_W:0] HI_MIN = (CNT_W+1)'(EXP_HIGH > TOL ? EXP_HIGH - TOL : 0);
  localparam logic [CNT_W:0] HI_MAX = (CNT_W+1)'(EXP_HIGH + TOL);
  localparam logic [CNT_W:0] LO_MIN = (CNT_W+1)'(EXP_LOW > TOL ? EXP_LOW - TOL : 0);
  localparam logic [CNT_W:0] LO_MAX = (CNT_W+1)'(EXP_LOW + TOL);
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_n;
  logic             sync1_q, sync2_q, sync_d_q;
  logic [1:0]       warm_q;
  logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
  logic [CNT_W-1:0] high_q, high_n, low_q, low_n, count_q, count_n;
  logic             valid_q, valid_n;
  logic             herr_q, herr_n, lerr_q, lerr_n, to_q, to_n;
  logic             herr_set, lerr_set, to_set;
  logic             edge_ok, rise, fall;
  logic [CNT_W:0]   cnt_ext;

  // Edges are ignored until the synchroniser and edge register hold real
  // samples, so a pulse already high when reset drops is not a rise.
  assign edge_ok = (warm_q == 2'd3);
  assign rise    = edge_ok &  sync2_q & ~sync_d_q;
  assign fall    = edge_ok & ~sync2_q &  sync_d_q;
  assign cnt_ext = {1'b0, cnt_q};
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync_d_q <= 1'b0;
      warm_q   <= 2'd0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      high_q   <= '0;
      low_q    <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      herr_q   <= 1'b0;
      lerr_q   <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      sync1_q  <= mon.pulse_in;
      sync2_q  <= sync1_q;
      sync_d_q <= sync2_q;
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      high_q   <= high_n;
      low_q    <= low_n;
      count_q  <= count_n;
      valid_q  <= valid_n;
      herr_q   <= herr_n;
      lerr_q   <= lerr_n;
      to_q     <= to_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_inc;
    high_n   = high_q;
    low_n    = low_q;
    count_n  = count_q;
    valid_n  = 1'b0;
    herr_set = 1'b0;
    lerr_set = 1'b0;
    to_set   = 1'b0;
    if (!mon.enable) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_n = '0;
          if (rise) begin
            state_n = HIGH;
            cnt_n   = CNT_ONE;
          end
        end
        HIGH: begin
          if (fall) begin
            high_n   = cnt_q;
            herr_set = (cnt_ext < HI_MIN) || (cnt_ext > HI_MAX);
            state_n  = LOW;
            cnt_n    = CNT_ONE;
          end else if (cnt_q >= TO_LIM) begin
            to_set  = 1'b1;
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
        LOW: begin
          if (rise) begin
            low_n    = cnt_q;
            lerr_set = (cnt_ext < LO_MIN) || (cnt_ext > LO_MAX);
            count_n  = count_q + CNT_ONE;
            valid_n  = 1'b1;
            state_n  = HIGH;
            cnt_n    = CNT_ONE;
          end else if (cnt_q >= TO_LIM) begin
            to_set  = 1'b1;
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
    // A detection in the same cycle as clear_errs wins.
    herr_n = herr_set | (herr_q & ~mon.clear_errs);
    lerr_n = lerr_set | (lerr_q & ~mon.clear_errs);
    to_n   = to_set   | (to_q   & ~mon.clear_errs);
  end

  // period_valid is a one-cycle strobe with no ready: a consumer samples
  // high_cycles/low_cycles/pulse_count in the cycle it is high.
  assign mon.high_cycles  = high_q;
  assign mon.low_cycles   = low_q;
  assign mon.period_valid = valid_q;
  assign mon.pulse_count  = count_q;
  assign mon.high_err     = herr_q;
  assign mon.low_err      = lerr_q;
  assign mon.timeout      = to_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_pulse_gen_monitor.sv
// Bench for pulse_gen_monitor: a cycle-level model predicts each completed
// period, the scoreboard compares it against every period_valid strobe.
module tb_pulse_gen_monitor;
  localparam int CNT_W       = 16;
  localparam int EXP_HIGH    = 10;
  localparam int EXP_LOW     = 10;
  localparam int TOL         = 1;
  localparam int TIMEOUT_CYC = 1000;
  localparam int W           = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  pulse_gen_monitor_if #(.CNT_W(CNT_W)) mon_if();

  pulse_gen_monitor #(
    .CNT_W(CNT_W), .EXP_HIGH(EXP_HIGH), .EXP_LOW(EXP_LOW),
    .TOL(TOL), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mon(mon_if),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- model and scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int   m_st, m_start, m_hi, m_count;
  logic m_en, m_herr, m_lerr, m_to;
  int   n_checks, n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic bit out_tol(input int v, input int e);
    int lo;
    lo = (e > TOL) ? e - TOL : 0;
    return (v < lo) || (v > e + TOL);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pulse(input logic v);
    int len;
    len     = cyc - m_start;
    m_start = cyc;
    if (m_st != 0 && len > TIMEOUT_CYC) begin
      m_to = 1'b1;
      m_st = 0;
    end
    if (v) begin
      if (m_st == 2) begin
        m_lerr  = m_lerr | out_tol(len, EXP_LOW);
        m_count = (m_count + 1) % 65536;
        exp_q.push_back({m_herr, m_lerr, 16'(m_count), 16'(len), 16'(m_hi)});
        m_st = 1;
      end else if (m_st == 0 && m_en) begin
        m_st = 1;
      end
    end else if (m_st == 1) begin
      m_hi   = len;
      m_herr = m_herr | out_tol(len, EXP_HIGH);
      m_st   = 2;
    end
    mon_if.pulse_in = v;
  endtask

  task automatic period(input int hi, input int lo);
    set_pulse(1'b1);
    hold(hi);
    set_pulse(1'b0);
    hold(lo);
  endtask

  task automatic clear_pulse();
    mon_if.clear_errs = 1'b1;
    hold(1);
    mon_if.clear_errs = 1'b0;
    m_herr = 1'b0;
    m_lerr = 1'b0;
    m_to   = 1'b0;
  endtask

  task automatic set_enable(input logic v);
    mon_if.enable = v;
    m_en = v;
    if (!v) m_st = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    hold(n);
    reset = 1'b0;
    m_st = 0; m_hi = 0; m_count = 0;
    m_herr = 1'b0; m_lerr = 1'b0; m_to = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_high"},  mon_if.high_cycles, 0);
    check({tag, "_low"},   mon_if.low_cycles, 0);
    check({tag, "_valid"}, mon_if.period_valid, 0);
    check({tag, "_count"}, mon_if.pulse_count, 0);
    check({tag, "_herr"},  mon_if.high_err, 0);
    check({tag, "_lerr"},  mon_if.low_err, 0);
    check({tag, "_to"},    mon_if.timeout, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!reset && mon_if.period_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", mon_if.period_valid, 0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("sb_high",  mon_if.high_cycles, e[15:0]);
        check("sb_low",   mon_if.low_cycles,  e[31:16]);
        check("sb_count", mon_if.pulse_count, e[47:32]);
        check("sb_lerr",  mon_if.low_err,     e[48]);
        check("sb_herr",  mon_if.high_err,    e[49]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0; n_fail = 0;
    m_st = 0; m_start = 0; m_hi = 0; m_count = 0;
    m_en = 1'b0; m_herr = 1'b0; m_lerr = 1'b0; m_to = 1'b0;
    reset = 1'b1;
    mon_if.enable = 1'b0;
    mon_if.pulse_in = 1'b0;
    mon_if.clear_errs = 1'b0;
    hold(3);
    reset = 1'b0;
    hold(1);
    check_all_zero("rst");

    // Nominal 10/10 periods, then random periods within tolerance.
    set_enable(1'b1);
    hold(2);
    for (int i = 0; i < 4; i++) period(10, 10);
    for (int i = 0; i < 4; i++) period($urandom_range(11, 9), $urandom_range(11, 9));

    // 13/7 periods: both durations out of tolerance, flags stay set.
    for (int i = 0; i < 3; i++) period(13, 7);
    set_pulse(1'b1);
    hold(6);
    check("herr_sticky", mon_if.high_err, 1);
    check("lerr_sticky", mon_if.low_err, 1);
    check("high_13", mon_if.high_cycles, 13);
    check("low_7", mon_if.low_cycles, 7);
    clear_pulse();
    check("herr_clr", mon_if.high_err, 0);
    check("lerr_clr", mon_if.low_err, 0);
    check("count_keep", mon_if.pulse_count, m_count);
    hold(3);

    // Stall low past the timeout limit.
    set_pulse(1'b0);
    hold(1200);
    check("timeout_set", mon_if.timeout, 1);
    check("timeout_state", dbg_state, 0);
    check("timeout_count", mon_if.pulse_count, m_count);
    for (int i = 0; i < 2; i++) period(10, 10);
    set_pulse(1'b1);
    hold(5);
    check("timeout_held", mon_if.timeout, 1);
    clear_pulse();
    check("timeout_clr", mon_if.timeout, 0);
    hold(4);
    set_pulse(1'b0);
    hold(10);

    // Reset in the middle of a high phase.
    set_pulse(1'b1);
    hold(5);
    do_reset(2);
    hold(1);
    check_all_zero("midrst");
    hold(2);
    set_pulse(1'b0);
    hold(10);
    for (int i = 0; i < 3; i++) period(10, 10);

    // Enable dropped for 500ns in the middle of LOW.
    set_pulse(1'b1);
    hold(10);
    set_pulse(1'b0);
    hold(4);
    set_enable(1'b0);
    hold(50);
    check("dis_count", mon_if.pulse_count, m_count);
    check("dis_state", dbg_state, 0);
    set_enable(1'b1);
    hold(6);
    period(10, 10);

    // clear_errs coincides with a high_err detection: the set wins.
    set_pulse(1'b1);
    hold(13);
    set_pulse(1'b0);
    hold(2);
    mon_if.clear_errs = 1'b1;
    m_lerr = 1'b0;
    m_to   = 1'b0;
    m_herr = out_tol(m_hi, EXP_HIGH);
    hold(1);
    mon_if.clear_errs = 1'b0;
    check("herr_set_wins", mon_if.high_err, 1);
    check("lerr_cleared", mon_if.low_err, 0);
    hold(7);
    period(10, 10);
    set_pulse(1'b1);
    hold(8);

    check("sb_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
